// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and source identifiers for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback sources (master) to arbiter (slave) bundle, including the register-file write port.
interface rf_write_arbiter_if #(
  parameter int DATA_W = rf_write_arbiter_pkg::DATA_W,
  parameter int REG_W  = rf_write_arbiter_pkg::REG_W
);

  logic              a_valid;
  logic              a_ready;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [REG_W-1:0]  b_reg;
  logic [DATA_W-1:0] b_data;
  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic              WriteReg;
  logic              busy;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, DstReg, DstData, WriteReg, busy
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, DstReg, DstData, WriteReg, busy
  );

endinterface

// File: rtl/rf_write_arbiter_wb_buffer.sv
// One-entry writeback slot: load has priority over retire so an entry can be replaced
// in the cycle it drains; contents are visible the cycle after load.
module rf_wb_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              retire,
  input  logic [REG_W-1:0]  ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [REG_W-1:0]  q_reg,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      q_reg  <= '0;
      q_data <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_reg  <= ld_reg;
      q_data <= ld_data;
    end else if (retire) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-source round-robin arbiter onto the single register-file write port; a write
// retires the cycle after acceptance at the earliest, and a source is ready when its slot is empty or draining.
module rf_write_arbiter #(
  parameter int DATA_W       = rf_write_arbiter_pkg::DATA_W,
  parameter int REG_W        = rf_write_arbiter_pkg::REG_W,
  parameter int R0_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);

  import rf_write_arbiter_pkg::*;

  localparam bit R0_FILTER = (R0_HARDWIRED != 0);

  logic              buf_a_valid, buf_b_valid;
  logic [REG_W-1:0]  buf_a_reg, buf_b_reg;
  logic [DATA_W-1:0] buf_a_data, buf_b_data;
  logic              grant_a, grant_b;
  logic              a_rdy, b_rdy;
  logic              load_a, load_b;
  logic              keep_a, keep_b;
  src_e              rr_ptr, age, winner;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;

  rf_wb_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .load    (load_a),
    .retire  (grant_a),
    .ld_reg  (bus.a_reg),
    .ld_data (bus.a_data),
    .valid   (buf_a_valid),
    .q_reg   (buf_a_reg),
    .q_data  (buf_a_data)
  );

  rf_wb_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .load    (load_b),
    .retire  (grant_b),
    .ld_reg  (bus.b_reg),
    .ld_data (bus.b_data),
    .valid   (buf_b_valid),
    .q_reg   (buf_b_reg),
    .q_data  (buf_b_data)
  );

  // Same destination: the older entry must land first so the newest value survives.
  always_comb begin
    winner = rr_ptr;
    if (buf_a_reg == buf_b_reg) begin
      winner = age;
    end
    grant_a = buf_a_valid & (!buf_b_valid | (winner == SRC_A));
    grant_b = buf_b_valid & (!buf_a_valid | (winner == SRC_B));
  end

  assign a_rdy  = !buf_a_valid | grant_a;
  assign b_rdy  = !buf_b_valid | grant_b;
  assign load_a = bus.a_valid & a_rdy;
  assign load_b = bus.b_valid & b_rdy;
  assign keep_a = buf_a_valid & !grant_a;
  assign keep_b = buf_b_valid & !grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= SRC_A;
      age    <= SRC_A;
    end else begin
      if (grant_a) begin
        rr_ptr <= other_src(SRC_A);
      end else if (grant_b) begin
        rr_ptr <= other_src(SRC_B);
      end
      if (load_a && load_b) begin
        age <= SRC_A;
      end else if (load_a && keep_b) begin
        age <= SRC_B;
      end else if (load_b && keep_a) begin
        age <= SRC_A;
      end
    end
  end

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    if (grant_a) begin
      sel_reg  = buf_a_reg;
      sel_data = buf_a_data;
    end else if (grant_b) begin
      sel_reg  = buf_b_reg;
      sel_data = buf_b_data;
    end
  end

  // A write to R0 still drains its slot and shows on the bus, only the enable is masked.
  assign bus.WriteReg = (grant_a | grant_b) & !(R0_FILTER && (sel_reg == '0));
  assign bus.DstReg   = sel_reg;
  assign bus.DstData  = sel_data;
  assign bus.a_ready  = a_rdy;
  assign bus.b_ready  = b_rdy;
  assign bus.busy     = buf_a_valid | buf_b_valid;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: per-cycle vector table, per-source retire scoreboard,
// shadow register file, and a hand-written asynchronous reset sequence.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.R0_HARDWIRED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          do_rst;
    bit          av;
    logic [3:0]  ar;
    logic [15:0] ad;
    bit          bv;
    logic [3:0]  br;
    logic [15:0] bd;
    bit          we;
    logic [3:0]  dreg;
    logic [15:0] ddata;
    bit          ardy;
    bit          brdy;
    bit          busy;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] a_q[$];
  logic [19:0] b_q[$];
  logic [15:0] exp_rf[16];
  logic [15:0] shadow[16];
  logic [19:0] seen;
  int          total = 0;
  int          bad = 0;

  task automatic add(input bit rs, input bit av, input logic [3:0] ar, input logic [15:0] ad,
                     input bit bv, input logic [3:0] br, input logic [15:0] bd,
                     input bit we, input logic [3:0] dreg, input logic [15:0] ddata,
                     input bit ardy, input bit brdy, input bit busy);
    vec_t v;
    v.do_rst = rs; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.we = we; v.dreg = dreg; v.ddata = ddata; v.ardy = ardy; v.brdy = brdy; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: each source retires in its own arrival order.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.WriteReg === 1'b1) begin
      seen = {bus.DstReg, bus.DstData};
      total++;
      if (a_q.size() > 0 && a_q[0] == seen) begin
        void'(a_q.pop_front());
      end else if (b_q.size() > 0 && b_q[0] == seen) begin
        void'(b_q.pop_front());
      end else begin
        bad++;
        $display("FAIL retire: got R%0d=%h, want head of A(%0d pending) or B(%0d pending)",
                 bus.DstReg, bus.DstData, a_q.size(), b_q.size());
      end
      shadow[bus.DstReg] = bus.DstData;
    end
  end

  task automatic drive(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                       input bit bv, input logic [3:0] br, input logic [15:0] bd);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
    #1;
    if (av && bus.a_ready && ar != 4'd0) begin
      a_q.push_back({ar, ad});
      exp_rf[ar] = ad;
    end
    if (bv && bus.b_ready && br != 4'd0) begin
      b_q.push_back({br, bd});
      exp_rf[br] = bd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    check("drained before reset", 32'(a_q.size() + b_q.size()), 32'd0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    logic [15:0] saved;
    for (int i = 0; i < 16; i++) begin
      exp_rf[i] = 16'h0;
      shadow[i] = 16'h0;
    end
    rst = 1'b0;
    bus.a_valid = 1'b0; bus.a_reg = 4'd0; bus.a_data = 16'h0;
    bus.b_valid = 1'b0; bus.b_reg = 4'd0; bus.b_data = 16'h0;

    // A alone, then a back-to-back A stream R4..R7.
    add(1, 1,4'd3,16'h1234, 0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    add(0, 1,4'd4,16'h0444, 0,4'd0,16'h0,    1,4'd3,16'h1234, 1,1,1);
    add(0, 1,4'd5,16'h0555, 0,4'd0,16'h0,    1,4'd4,16'h0444, 1,1,1);
    add(0, 1,4'd6,16'h0666, 0,4'd0,16'h0,    1,4'd5,16'h0555, 1,1,1);
    add(0, 1,4'd7,16'h0777, 0,4'd0,16'h0,    1,4'd6,16'h0666, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    1,4'd7,16'h0777, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    // Both contending on different registers: strict alternation.
    add(1, 1,4'd1,16'hA001, 1,4'd2,16'hB001, 0,4'd0,16'h0000, 1,1,0);
    add(0, 1,4'd1,16'hA002, 1,4'd2,16'hB001, 1,4'd1,16'hA001, 1,0,1);
    add(0, 1,4'd1,16'hA002, 1,4'd2,16'hB002, 1,4'd2,16'hB001, 0,1,1);
    add(0, 1,4'd1,16'hA003, 1,4'd2,16'hB002, 1,4'd1,16'hA002, 1,0,1);
    add(0, 1,4'd1,16'hA003, 1,4'd2,16'hB003, 1,4'd2,16'hB002, 0,1,1);
    add(0, 0,4'd0,16'h0,    1,4'd2,16'hB003, 1,4'd1,16'hA003, 1,0,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    1,4'd2,16'hB003, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    // Simultaneous capture to R7 after an A grant: A is older and must go first.
    add(1, 1,4'd3,16'h0301, 0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    add(0, 1,4'd7,16'h07AA, 1,4'd7,16'h07BB, 1,4'd3,16'h0301, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    1,4'd7,16'h07AA, 1,0,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    1,4'd7,16'h07BB, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    // B then A to R7: A's value is the survivor.
    add(1, 0,4'd0,16'h0,    1,4'd7,16'h00BB, 0,4'd0,16'h0000, 1,1,0);
    add(0, 1,4'd7,16'h00AA, 0,4'd0,16'h0,    1,4'd7,16'h00BB, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    1,4'd7,16'h00AA, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    // R0 write drains with the enable masked.
    add(1, 1,4'd0,16'hFFFF, 0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'hFFFF, 1,1,1);
    add(0, 0,4'd0,16'h0,    0,4'd0,16'h0,    0,4'd0,16'h0000, 1,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      total++;
      if ({bus.WriteReg, bus.DstReg, bus.DstData, bus.a_ready, bus.b_ready, bus.busy} !==
          {tbl[i].we, tbl[i].dreg, tbl[i].ddata, tbl[i].ardy, tbl[i].brdy, tbl[i].busy}) begin
        bad++;
        $display("FAIL row%0d: got we=%0b reg=%0d data=%h ardy=%0b brdy=%0b busy=%0b, want we=%0b reg=%0d data=%h ardy=%0b brdy=%0b busy=%0b",
                 i, bus.WriteReg, bus.DstReg, bus.DstData, bus.a_ready, bus.b_ready, bus.busy,
                 tbl[i].we, tbl[i].dreg, tbl[i].ddata, tbl[i].ardy, tbl[i].brdy, tbl[i].busy);
      end
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
    end
    check("drained after table", 32'(a_q.size() + b_q.size()), 32'd0);

    // Asynchronous reset with both slots holding writes to R5.
    saved = exp_rf[5];
    bus.a_valid = 1'b1; bus.a_reg = 4'd5; bus.a_data = 16'hAAAA;
    bus.b_valid = 1'b1; bus.b_reg = 4'd5; bus.b_data = 16'hBBBB;
    @(posedge clk);
    #2;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    check("busy both loaded", 32'(bus.busy), 32'd1);
    check("we before reset", 32'(bus.WriteReg), 32'd1);
    rst = 1'b0;
    #1;
    check("we in reset", 32'(bus.WriteReg), 32'd0);
    check("busy in reset", 32'(bus.busy), 32'd0);
    check("readies in reset", 32'({bus.a_ready, bus.b_ready}), 32'd3);
    check("dst in reset", 32'({bus.DstReg, bus.DstData}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("R5 untouched after reset", 32'(shadow[5]), 32'(saved));
    check("idle after reset", 32'({bus.WriteReg, bus.busy}), 32'd0);

    for (int r = 0; r < 16; r++) begin
      check($sformatf("regfile R%0d", r), 32'(shadow[r]), 32'(exp_rf[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
